bus_bridge_mc: RTL

Parametrised multi-channel bus bridge between the CPU data port and its memory plus `NUM_IO` IO peripherals. Each access is decoded by address, forwarded to exactly one target over a req/ack handshake and answered with a registered one-cycle `cpu_ready` pulse. Decode misses and targets that never acknowledge are reported through `cpu_err`, so a dead peripheral cannot stall the core. It sits between the CPU load/store unit and the data memory / IO blocks, replacing the purely combinational bus.

---
 rtl/bus_bridge_mc.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bus_bridge_mc.sv
// Multi-channel CPU bus bridge: address-decodes each access to memory or one of
// NUM_IO peripherals over req/ack, with decode-miss and ack-timeout error reporting.
module bus_bridge_mc #(
    parameter int              DW      = 32,
    parameter int              AW      = 32,
    parameter int              NUM_IO  = 4,
    parameter logic [AW-13:0]  IO_PAGE = 20'hFFFFF,
    parameter int              TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [AW-1:0]        cpu_addr,
    input  logic [DW-1:0]        cpu_wdata,
    output logic                 cpu_ready,
    output logic [DW-1:0]        cpu_rdata,
    output logic                 cpu_err,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic                 mem_ack,
    input  logic [DW-1:0]        mem_rdata,
    output logic [NUM_IO-1:0]    io_req,
    output logic                 io_we,
    output logic [11:0]          io_addr,
    output logic [DW-1:0]        io_wdata,
    input  logic [NUM_IO-1:0]    io_ack,
    input  logic [NUM_IO*DW-1:0] io_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    logic [1:0]        state;
    logic [TW-1:0]     timer;
    logic              we_q;
    logic              io_page;
    logic [3:0]        ch;
    logic              ch_ok;
    logic [NUM_IO-1:0] io_sel;
    logic              ack;
    logic [DW-1:0]     ack_data;

    always_comb begin
        io_page = (cpu_addr[AW-1:12] == IO_PAGE);
        ch      = cpu_addr[11:8];
        ch_ok   = ({1'b0, ch} < 5'(NUM_IO));
        io_sel  = '0;
        for (int unsigned i = 0; i < NUM_IO; i++) begin
            io_sel[i] = ({1'b0, ch} == 5'(i));
        end
    end

    // The req registers are only high in WAIT and only for the decoded target,
    // so masking each ack with its own req ignores acks from every other source.
    always_comb begin
        ack      = (mem_req & mem_ack) | (|(io_req & io_ack));
        ack_data = '0;
        if (mem_req) begin
            ack_data = mem_rdata;
        end
        for (int unsigned i = 0; i < NUM_IO; i++) begin
            if (io_req[i]) begin
                ack_data = io_rdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            we_q      <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '1;
            mem_wdata <= '0;
            io_req    <= '0;
            io_we     <= 1'b0;
            io_addr   <= 12'hFFF;
            io_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    cpu_rdata <= '0;
                    timer     <= '0;
                    if (cpu_req) begin
                        we_q <= cpu_we;
                        if (!io_page) begin
                            state     <= WAIT;
                            mem_req   <= 1'b1;
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end else if (ch_ok) begin
                            state    <= WAIT;
                            io_req   <= io_sel;
                            io_we    <= cpu_we;
                            io_addr  <= cpu_addr[11:0];
                            io_wdata <= cpu_wdata;
                        end else begin
                            state     <= RESP;
                            cpu_ready <= 1'b1;
                            cpu_err   <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // An ack in the timeout cycle still completes without error.
                    if (ack || (timer == TMAX)) begin
                        state     <= RESP;
                        cpu_ready <= 1'b1;
                        cpu_err   <= ~ack;
                        cpu_rdata <= (ack && !we_q) ? ack_data : '0;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '1;
                        mem_wdata <= '0;
                        io_req    <= '0;
                        io_we     <= 1'b0;
                        io_addr   <= 12'hFFF;
                        io_wdata  <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    cpu_rdata <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
